jacobi_solver: RTL and testbench



---
 rtl/jacobi_pkg.sv | 13 +
 rtl/jacobi_solver_if.sv | 30 +++
 rtl/jacobi_solver_stencil_pe.sv | 32 +++
 rtl/jacobi_solver.sv | 111 +++++++++++
 tb/tb_jacobi_solver.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/jacobi_pkg.sv
// Shared types and width constants for the 1-D Jacobi relaxation solver.
package jacobi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } jacobi_state_e;

  // h2 + u[i-1] + u[i+1] of three WIDTH-bit terms needs two extra bits.
  localparam int SUM_GUARD = 2;

endpackage

// File: rtl/jacobi_solver_if.sv
// Control and data bundle between a solver client (master) and jacobi_solver (slave).
import jacobi_pkg::*;

interface jacobi_solver_if #(
  parameter int NU     = 10,
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
);
  // start is a level request sampled only while the solver is idle; uin_arr and
  // max_iter are captured on that same edge. done is a single-cycle completion strobe.
  logic                  start;
  logic [ITER_W-1:0]     max_iter;
  logic [NU*WIDTH-1:0]   uin_arr;
  logic [NU*WIDTH-1:0]   uou_arr;
  logic                  busy;
  logic                  done;
  logic                  converged;
  logic [ITER_W-1:0]     iter_cnt;
  jacobi_state_e         state;

  modport master (
    output start, max_iter, uin_arr,
    input  uou_arr, busy, done, converged, iter_cnt, state
  );

  modport slave (
    input  start, max_iter, uin_arr,
    output uou_arr, busy, done, converged, iter_cnt, state
  );
endinterface

// File: rtl/jacobi_solver_stencil_pe.sv
// Combinational three-point stencil: new = sat((h2 + left + right) >> 1), plus a tolerance flag.
module stencil_pe
  import jacobi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EXPON = 3,
  parameter int TOL   = 0
) (
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] center,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] next_val,
  output logic             within_tol
);
  localparam int              SW    = WIDTH + SUM_GUARD;
  localparam logic [WIDTH-1:0] H2   = WIDTH'(1 << EXPON);
  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH:0]   TOL_V = (WIDTH + 1)'(TOL);

  logic [SW-1:0]    sum;
  logic [SW-1:0]    half;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = SW'(H2) + SW'(left) + SW'(right);
    half     = sum >> 1;
    next_val = (half > SW'(MAXV)) ? MAXV : half[WIDTH-1:0];
    diff     = (next_val >= center) ? (next_val - center) : (center - next_val);
    within_tol = ({1'b0, diff} <= TOL_V);
  end

endmodule

// File: rtl/jacobi_solver.sv
// Jacobi solver for a 1-D grid with fixed boundaries: one full synchronous sweep per clock in RUN.
module jacobi_solver
  import jacobi_pkg::*;
#(
  parameter int NU     = 10,
  parameter int WIDTH  = 8,
  parameter int EXPON  = 3,
  parameter int ITER_W = 8,
  parameter int TOL    = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  jacobi_solver_if.slave bus
);
  localparam int GW    = NU * WIDTH;
  localparam int INNER = NU - 2;

  jacobi_state_e     state;
  logic [GW-1:0]     grid;
  logic [GW-1:0]     sweep_grid;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W-1:0] max_lat;
  logic              busy_q;
  logic              done_q;
  logic              conv_q;
  logic [INNER-1:0]  tol_flags;
  logic              all_tol;
  logic              limit_hit;

  // Boundary points pass through untouched; interior points come from the PEs.
  assign sweep_grid[WIDTH-1:0]     = grid[WIDTH-1:0];
  assign sweep_grid[GW-1 -: WIDTH] = grid[GW-1 -: WIDTH];

  for (genvar i = 1; i <= NU - 2; i++) begin : g_pe
    stencil_pe #(
      .WIDTH (WIDTH),
      .EXPON (EXPON),
      .TOL   (TOL)
    ) u_pe (
      .left       (grid[(i-1)*WIDTH +: WIDTH]),
      .center     (grid[i*WIDTH +: WIDTH]),
      .right      (grid[(i+1)*WIDTH +: WIDTH]),
      .next_val   (sweep_grid[i*WIDTH +: WIDTH]),
      .within_tol (tol_flags[i-1])
    );
  end

  assign all_tol   = &tol_flags;
  assign limit_hit = ((iter_cnt + ITER_W'(1)) == max_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grid     <= '0;
      iter_cnt <= '0;
      max_lat  <= '0;
      conv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            grid     <= bus.uin_arr;
            max_lat  <= bus.max_iter;
            iter_cnt <= '0;
            conv_q   <= 1'b0;
            if (bus.max_iter == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          grid     <= sweep_grid;
          iter_cnt <= iter_cnt + ITER_W'(1);
          if (all_tol) conv_q <= 1'b1;
          // max_lat >= 1 here, so the limit compare fires before iter_cnt can wrap.
          if (all_tol || limit_hit) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uou_arr   = grid;
  assign bus.iter_cnt  = iter_cnt;
  assign bus.converged = conv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_jacobi_solver.sv
// Scoreboard bench for jacobi_solver with NU=4, WIDTH=8, h2=8, TOL=0.
module tb_jacobi_solver;
  import jacobi_pkg::*;

  localparam int NU     = 4;
  localparam int WIDTH  = 8;
  localparam int EXPON  = 3;
  localparam int ITER_W = 8;
  localparam int TOL    = 0;
  localparam int GW     = NU * WIDTH;
  localparam int EXP_W  = 8 + GW + ITER_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               e0_q[$];

  logic [EXP_W-1:0] mon_exp;
  logic [EXP_W-1:0] mon_act;
  int               mon_e0;

  jacobi_solver_if #(.NU(NU), .WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

  jacobi_solver #(
    .NU     (NU),
    .WIDTH  (WIDTH),
    .EXPON  (EXPON),
    .ITER_W (ITER_W),
    .TOL    (TOL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [GW-1:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || e0_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_e0  = e0_q.pop_front();
        mon_act = {8'(cyc - mon_e0), bus.uou_arr, bus.iter_cnt, bus.converged};
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL solve_result: got lat=%0d grid=%h iter=%0d conv=%0b, expected lat=%0d grid=%h iter=%0d conv=%0b",
                   mon_act[EXP_W-1 -: 8], mon_act[GW+ITER_W : ITER_W+1], mon_act[ITER_W:1], mon_act[0],
                   mon_exp[EXP_W-1 -: 8], mon_exp[GW+ITER_W : ITER_W+1], mon_exp[ITER_W:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(output int busy_cycles);
    bit reached;
    busy_cycles = 0;
    reached = 1'b0;
    for (int k = 0; k < 64 && !reached; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.state == ST_IDLE && bus.done === 1'b0) reached = 1'b1;
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got state=%0d after 64 cycles, expected IDLE", bus.state);
    end
  endtask

  task automatic run_solve(input logic [GW-1:0] uin, input logic [7:0] mx,
                           input logic [GW-1:0] exp_grid, input logic [7:0] exp_iter,
                           input logic exp_conv, input logic [7:0] exp_lat, input string name);
    int bc;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.uin_arr  = uin;
    bus.max_iter = mx;
    @(posedge clk);
    #1;
    e0_q.push_back(cyc);
    exp_q.push_back({exp_lat, exp_grid, exp_iter, exp_conv});
    bus.start = 1'b0;
    wait_idle(bc);
    check({name, "_busy_cycles"}, 64'(bc), 64'(exp_iter));
    check({name, "_hold_grid"}, 64'(bus.uou_arr), 64'(exp_grid));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_grid"}, 64'(bus.uou_arr), 64'd0);
    check({name, "_iter"}, 64'(bus.iter_cnt), 64'd0);
    check({name, "_conv"}, 64'(bus.converged), 64'd0);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_state"}, 64'(bus.state), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    int e0;
    bus.start    = 1'b0;
    bus.max_iter = '0;
    bus.uin_arr  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_solve(pack4(0, 0, 0, 0),         8'd1,  pack4(0, 4, 4, 0),         8'd1, 1'b0, 8'd1, "single");
    run_solve(pack4(0, 0, 0, 0),         8'd10, pack4(0, 7, 7, 0),         8'd4, 1'b1, 8'd4, "converge");
    run_solve(pack4(255, 255, 255, 255), 8'd1,  pack4(255, 255, 255, 255), 8'd1, 1'b1, 8'd1, "saturate");
    run_solve(pack4(3, 9, 200, 5),       8'd0,  pack4(3, 9, 200, 5),       8'd0, 1'b0, 8'd0, "zero_limit");
    run_solve(pack4(0, 7, 7, 0),         8'd1,  pack4(0, 7, 7, 0),         8'd1, 1'b1, 8'd1, "conv_at_limit");
    run_solve(pack4(100, 0, 0, 50),      8'd3,  pack4(100, 82, 63, 50),    8'd3, 1'b0, 8'd3, "limit");

    // Reset two sweeps into a ten-sweep solve.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.uin_arr  = pack4(0, 0, 0, 0);
    bus.max_iter = 8'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_iter_before_reset", 64'(bus.iter_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_solve(pack4(0, 0, 0, 0), 8'd2, pack4(0, 6, 6, 0), 8'd2, 1'b0, 8'd2, "after_reset");

    // start held high: ignored in RUN/DONE, relaunches at the first IDLE edge (E0+4).
    @(negedge clk);
    bus.start    = 1'b1;
    bus.uin_arr  = pack4(0, 0, 0, 0);
    bus.max_iter = 8'd2;
    @(posedge clk);
    #1;
    e0 = cyc;
    e0_q.push_back(e0);
    exp_q.push_back({8'd2, pack4(0, 6, 6, 0), 8'd2, 1'b0});
    e0_q.push_back(e0 + 4);
    exp_q.push_back({8'd1, pack4(10, 24, 34, 40), 8'd1, 1'b0});
    bus.uin_arr  = pack4(10, 20, 30, 40);
    bus.max_iter = 8'd1;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle(bc);
    check("held_busy_cycles", 64'(bc), 64'd1);
    check("held_hold_grid", 64'(bus.uou_arr), 64'(pack4(10, 24, 34, 40)));

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
